// File: rtl/dmem_pipe.sv
// Pipelined 32-bit data memory with byte/half/word loads and stores and a valid/ready request/response handshake.
// Build option DMEM_MISALIGN_EN: split misaligned accesses into two word accesses instead of flagging them as errors.
module dmem_pipe #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 2**(ADDR_W-2)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              WEN,
  input  logic [1:0]        BYTE_SEL,
  input  logic              SIGN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       DATA_OUT,
  output logic              ERR
);

  localparam int IDX_W = ADDR_W - 2;
`ifdef DMEM_MISALIGN_EN
  localparam bit MisalignEn = 1'b1;
`else
  localparam bit MisalignEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC2, RSP} state_e;

  state_e            state_q, state_d;
  logic              ready_en_q;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];

  // Second-half context of a split access, captured at acceptance.
  logic [IDX_W-1:0]  hi_idx_q;
  logic [3:0]        hi_be_q;
  logic [31:0]       hi_wdata_q, lo_rdata_q;
  logic [1:0]        off_q, bsel_q;
  logic              sign_q, wen_q;

  logic [IDX_W-1:0]  req_idx, rd_idx, next_idx;
  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic [7:0]        be8;
  logic [63:0]       wdata64;
  logic              in_range, split, req_err, accept;
  logic [31:0]       lo_word, hi_word;

  // Select the addressed bytes out of a two-word window and extend to 32 bits.
  function automatic logic [31:0] load_fmt(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] o, input logic [1:0] bsel,
                                           input logic sgn);
    logic [31:0] v;
    v = 32'({hi, lo} >> {o, 3'b000});
    case (bsel)
      2'b00:   return {{24{sgn & v[7]}}, v[7:0]};
      2'b01:   return {{16{sgn & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign req_idx  = ADDR[ADDR_W-1:2];
  assign off      = ADDR[1:0];
  assign in_range = ({1'b0, req_idx} < (IDX_W+1)'(DEPTH));
  assign rd_idx   = in_range ? req_idx : '0;
  assign next_idx = (req_idx == IDX_W'(DEPTH - 1)) ? '0 : req_idx + IDX_W'(1);

  always_comb begin
    case (BYTE_SEL)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign be8       = {4'b0000, size_mask} << off;
  assign wdata64   = {32'h0, DATA_IN} << {off, 3'b000};
  assign split     = |be8[7:4];
  assign req_err   = (BYTE_SEL == 2'b11) || !in_range || (split && !MisalignEn);
  assign REQ_READY = ready_en_q && ((state_q == IDLE) || ((state_q == RSP) && RSP_READY));
  assign accept    = REQ_VALID && REQ_READY;
  assign lo_word   = mem_q[rd_idx];
  assign hi_word   = mem_q[hi_idx_q];

  assign RSP_VALID = (state_q == RSP);
  assign DATA_OUT  = data_q;
  assign ERR       = err_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE, RSP: begin
        if (accept) begin
          if (split && !req_err) begin
            state_d = ACC2;
          end else begin
            state_d = RSP;
            err_d   = req_err;
            data_d  = (req_err || WEN) ? 32'h0 : load_fmt(32'h0, lo_word, off, BYTE_SEL, SIGN);
          end
        end else if (state_q == RSP && RSP_READY) begin
          state_d = IDLE;
        end
      end
      ACC2: begin
        state_d = RSP;
        err_d   = 1'b0;
        data_d  = wen_q ? 32'h0 : load_fmt(hi_word, lo_rdata_q, off_q, bsel_q, sign_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
      hi_idx_q   <= '0;
      hi_be_q    <= 4'h0;
      hi_wdata_q <= 32'h0;
      lo_rdata_q <= 32'h0;
      off_q      <= 2'b00;
      bsel_q     <= 2'b00;
      sign_q     <= 1'b0;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      data_q     <= data_d;
      err_q      <= err_d;
      if (accept) begin
        hi_idx_q   <= next_idx;
        hi_be_q    <= be8[7:4];
        hi_wdata_q <= wdata64[63:32];
        lo_rdata_q <= lo_word;
        off_q      <= off;
        bsel_q     <= BYTE_SEL;
        sign_q     <= SIGN;
        wen_q      <= WEN;
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive RST_N and writes are gated by accept/ACC2 only.
  always_ff @(posedge CLK) begin
    if (accept && WEN && !req_err) begin
      for (int i = 0; i < 4; i++)
        if (be8[i]) mem_q[req_idx][8*i +: 8] <= wdata64[8*i +: 8];
    end
    if (state_q == ACC2 && wen_q) begin
      for (int i = 0; i < 4; i++)
        if (hi_be_q[i]) mem_q[hi_idx_q][8*i +: 8] <= hi_wdata_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Randomized and directed bench for dmem_pipe against a byte-level reference model with an in-order response queue.
module tb_dmem_pipe;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 2**(ADDR_W-2);
`ifdef DMEM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic              WEN = 1'b0;
  logic [1:0]        BYTE_SEL = 2'b00;
  logic              SIGN = 1'b0;
  logic [ADDR_W-1:0] ADDR = '0;
  logic [31:0]       DATA_IN = 32'h0;
  logic              RSP_VALID;
  logic              RSP_READY = 1'b0;
  logic [31:0]       DATA_OUT;
  logic              ERR;

  dmem_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .WEN(WEN), .BYTE_SEL(BYTE_SEL), .SIGN(SIGN), .ADDR(ADDR), .DATA_IN(DATA_IN),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .DATA_OUT(DATA_OUT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]      data;
    logic             err;
    int               due;
    int               np;
    logic [2:0][31:0] pa;
    logic [2:0][7:0]  pd;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mdl [DEPTH*4];
  logic [31:0] last_data;
  logic        last_err;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Byte-by-byte reference: returns the response and the high-word bytes a split store writes later.
  function automatic exp_t model(input logic w, input logic [1:0] bs, input logic sg,
                                 input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_t e;
    int size, off, idx, lane, wi, ba;
    logic [31:0] val;
    e.data = 32'h0; e.err = 1'b0; e.np = 0; e.pa = '0; e.pd = '0;
    size = (bs == 2'b00) ? 1 : (bs == 2'b01) ? 2 : 4;
    off  = int'(a[1:0]);
    idx  = int'(a) / 4;
    e.err = (bs == 2'b11) || (idx >= DEPTH) || ((off + size > 4) && !MIS_EN);
    e.due = (!e.err && off + size > 4) ? 2 : 1;
    if (e.err) return e;
    val = 32'h0;
    for (int k = 0; k < size; k++) begin
      lane = off + k;
      wi   = (lane < 4) ? idx : (idx + 1) % DEPTH;
      ba   = wi * 4 + lane % 4;
      if (w) begin
        if (lane < 4) mdl[ba] = d[8*k +: 8];
        else begin
          e.pa[e.np] = 32'(ba);
          e.pd[e.np] = d[8*k +: 8];
          e.np++;
        end
      end else begin
        val[8*k +: 8] = mdl[ba];
      end
    end
    if (!w && sg && size < 4 && val[8*size-1])
      for (int b = 8*size; b < 32; b++) val[b] = 1'b1;
    e.data = w ? 32'h0 : val;
    return e;
  endfunction

  task automatic step(input logic v, input logic w, input logic [1:0] bs, input logic sg,
                      input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic rr,
                      output bit acc);
    logic ev, er;
    exp_t e;
    @(negedge CLK);
    REQ_VALID = v; WEN = w; BYTE_SEL = bs; SIGN = sg; ADDR = a; DATA_IN = d; RSP_READY = rr;
    #1;
    ev = (q.size() > 0) && (cyc >= q[0].due);
    er = (q.size() == 0) || (ev && rr);
    check("rsp_valid", 32'(RSP_VALID), 32'(ev));
    check("req_ready", 32'(REQ_READY), 32'(er));
    if (ev) begin
      check("data_out", DATA_OUT, q[0].data);
      check("err", 32'(ERR), 32'(q[0].err));
      if (rr) begin
        for (int i = 0; i < q[0].np; i++) mdl[q[0].pa[i]] = q[0].pd[i];
        last_data = DATA_OUT;
        last_err  = ERR;
        void'(q.pop_front());
      end
    end
    acc = v && REQ_READY;
    if (acc) begin
      e = model(w, bs, sg, a, d);
      e.due = cyc + e.due;
      q.push_back(e);
    end
  endtask

  task automatic req(input logic w, input logic [1:0] bs, input logic sg,
                     input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bit acc;
    int n = 0;
    do begin
      step(1'b1, w, bs, sg, a, d, 1'b1, acc);
      n++;
    end while (!acc && n < 20);
    check("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      step(1'b0, 1'b0, 2'b10, 1'b0, '0, 32'h0, 1'b1, acc);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_req_ready", 32'(REQ_READY), 32'd0);
    check("rst_data_out", DATA_OUT, 32'h0);
    check("rst_err", 32'(ERR), 32'd0);
    q.delete();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("ready_before_edge", 32'(REQ_READY), 32'd0);
    @(posedge CLK);
    #1;
    check("ready_after_edge", 32'(REQ_READY), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc;
    #1;
    do_reset();

    for (int i = 0; i < 32; i++) req(1'b1, 2'b10, 1'b0, ADDR_W'(i * 4), $urandom);
    for (int i = DEPTH - 4; i < DEPTH; i++) req(1'b1, 2'b10, 1'b0, ADDR_W'(i * 4), $urandom);
    drain();

    // Word store then load, back to back.
    req(1'b1, 2'b10, 1'b0, 'h0, 32'hDEADBEEF);
    req(1'b0, 2'b10, 1'b0, 'h0, 32'h0);
    drain();
    check("ld_word0", last_data, 32'hDEADBEEF);
    check("ld_word0_err", 32'(last_err), 32'd0);

    // Byte store, signed and unsigned byte loads.
    req(1'b1, 2'b00, 1'b0, 'h8, 32'hDEADBEEF);
    req(1'b0, 2'b00, 1'b1, 'h8, 32'h0);
    drain();
    check("ld_byte_sext", last_data, 32'hFFFFFFEF);
    req(1'b0, 2'b00, 1'b0, 'h8, 32'h0);
    drain();
    check("ld_byte_zext", last_data, 32'h000000EF);

    // Misaligned word store straddling words at 4 and 8.
    req(1'b1, 2'b10, 1'b0, 'h4, 32'h0);
    req(1'b1, 2'b10, 1'b0, 'h8, 32'h0);
    req(1'b1, 2'b10, 1'b0, 'h6, 32'h11223344);
    drain();
    check("mis_store_err", 32'(last_err), MIS_EN ? 32'd0 : 32'd1);
    req(1'b0, 2'b10, 1'b0, 'h4, 32'h0);
    drain();
    check("mis_word4", last_data, MIS_EN ? 32'h33440000 : 32'h0);
    req(1'b0, 2'b10, 1'b0, 'h8, 32'h0);
    drain();
    check("mis_word8", last_data, MIS_EN ? 32'h00001122 : 32'h0);

    // Back-pressure: response held, next request waits, then accepted on release.
    req(1'b0, 2'b10, 1'b0, 'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'b10, 1'b0, 'h4, 32'h0, 1'b0, acc);
      check("hold_no_accept", 32'(acc), 32'd0);
      check("hold_data", DATA_OUT, 32'hDEADBEEF);
    end
    step(1'b1, 1'b0, 2'b10, 1'b0, 'h4, 32'h0, 1'b1, acc);
    check("accept_on_release", 32'(acc), 32'd1);
    drain();

    // Reserved size: error, no write.
    req(1'b1, 2'b11, 1'b0, 'h0, 32'h12345678);
    drain();
    check("rsv_err", 32'(last_err), 32'd1);
    check("rsv_data", last_data, 32'h0);
    req(1'b0, 2'b10, 1'b0, 'h0, 32'h0);
    drain();
    check("rsv_no_write", last_data, 32'hDEADBEEF);

    // Reset while the second half of a split store is pending.
    step(1'b1, 1'b1, 2'b10, 1'b0, 'h6, 32'hAABBCCDD, 1'b1, acc);
    check("split_accept", 32'(acc), 32'd1);
    @(posedge CLK);
    #1;
    do_reset();
    req(1'b0, 2'b10, 1'b0, 'h4, 32'h0);
    drain();
    check("rst_acc2_word4", last_data, MIS_EN ? 32'hCCDD0000 : 32'h0);
    req(1'b0, 2'b10, 1'b0, 'h8, 32'h0);
    drain();
    check("rst_acc2_word8", last_data, MIS_EN ? 32'h00001122 : 32'h0);

    // Random traffic with random back-pressure over low and top-of-memory regions.
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] a;
      if ($urandom_range(7) == 0) a = ADDR_W'(DEPTH * 4 - 16 + $urandom_range(15));
      else a = ADDR_W'($urandom_range(127));
      step(($urandom_range(3) != 0), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
           ($urandom_range(3) != 0), acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
